// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one line-wide memory port between two requesters
//
// Serializes cache-line transactions from two requesters onto a single
// enable/ack memory port. Port 0 is the instruction cache, port 1 the data
// cache. One transaction is in flight at a time; ties are broken against the
// port granted last. Transactions that see no mem_ack_i within TIMEOUT BUSY
// cycles are aborted and reported with err_o.
//
// Ports:
//   clk_i, rst_i                 clock (rising edge), synchronous active-low reset
//   reqN_i, weN_i                request (held until ackN_o) and write qualifier
//   addrN_i, wdataN_i            line address and write data of port N
//   ackN_o                       one-cycle completion pulse for port N
//   rdata_o                      read data, valid with the ack pulse of a read
//   err_o                        pulses with ackN_o when the transaction timed out
//   timeout_flag_o               sticky timeout indicator, cleared only by reset
//   mem_enable_o, mem_write_o    memory request (held until ack) and write qualifier
//   mem_addr_o, mem_data_o       memory address and write data
//   mem_ack_i, mem_data_i        memory completion pulse and read data

module mem_arbiter #(
    parameter int DATA_W  = 256,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    output logic              ack0_o,

    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              ack1_o,

    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic              timeout_flag_o,

    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t            state_q,      state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q,      grant_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic              ack0_q,       ack0_d;
    logic              ack1_q,       ack1_d;
    logic              err_q,        err_d;
    logic              flag_q,       flag_d;
    logic [DATA_W-1:0] rdata_q,      rdata_d;
    logic              mem_en_q,     mem_en_d;
    logic              mem_wr_q,     mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0] mem_data_q,   mem_data_d;

    // Port that would win if a grant were issued this cycle: on a tie the
    // port that did not win last time, otherwise whichever port is asking.
    logic pick;
    assign pick = (req0_i && req1_i) ? ~last_grant_q : req1_i;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        err_d        = 1'b0;
        flag_d       = flag_q;
        rdata_d      = rdata_q;
        mem_en_d     = mem_en_q;
        mem_wr_d     = mem_wr_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;

        case (state_q)
            S_IDLE: begin
                if (req0_i || req1_i) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    mem_en_d     = 1'b1;
                    mem_wr_d     = pick ? we1_i    : we0_i;
                    mem_addr_d   = pick ? addr1_i  : addr0_i;
                    mem_data_d   = pick ? wdata1_i : wdata0_i;
                    cnt_d        = '0;
                    state_d      = S_BUSY;
                end
            end

            S_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // An ack in the final cycle still completes normally.
                if (mem_ack_i || (cnt_q == CNT_LAST)) begin
                    mem_en_d = 1'b0;
                    mem_wr_d = 1'b0;
                    ack0_d   = ~grant_q;
                    ack1_d   = grant_q;
                    cnt_d    = '0;
                    state_d  = S_RESP;
                    if (mem_ack_i) begin
                        if (!mem_wr_q) begin
                            rdata_d = mem_data_i;
                        end
                    end else begin
                        err_d  = 1'b1;
                        flag_d = 1'b1;
                    end
                end
            end

            S_RESP: begin
                // Requests are not sampled here: the requester drops its
                // request at the edge that ends this cycle.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            cnt_q        <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err_q        <= 1'b0;
            flag_q       <= 1'b0;
            rdata_q      <= '0;
            mem_en_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            err_q        <= err_d;
            flag_q       <= flag_d;
            rdata_q      <= rdata_d;
            mem_en_q     <= mem_en_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

    assign ack0_o         = ack0_q;
    assign ack1_o         = ack1_q;
    assign err_o          = err_q;
    assign timeout_flag_o = flag_q;
    assign rdata_o        = rdata_q;
    assign mem_enable_o   = mem_en_q;
    assign mem_write_o    = mem_wr_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_data_o     = mem_data_q;

endmodule
